// File: rtl/pq_pkg.sv
// Shared definitions for the coefficient datapath: modulus constants and the
// sequencer state encoding used by the modular multiplier.
package pq_pkg;

  localparam int Q_WIDTH = 23;
  localparam logic [Q_WIDTH-1:0] DILITHIUM_Q = 23'd8380417;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of iterations needed to consume an nb-bit multiplier, radix_bits per cycle.
  function automatic int steps_for(input int nb, input int radix_bits);
    return (nb + radix_bits - 1) / radix_bits;
  endfunction

endpackage

// File: rtl/mod_dbl_add.sv
// One combinational double-and-add step of MSB-first modular multiplication:
// r_next = (2*r + b_bit*a) mod q, given r < q and a < q.
module mod_dbl_add #(
  parameter int NB_BIT = 23
) (
  input  logic [NB_BIT-1:0] r,
  input  logic              b_bit,
  input  logic [NB_BIT-1:0] a,
  input  logic [NB_BIT-1:0] q,
  output logic [NB_BIT-1:0] r_next
);

  logic [NB_BIT:0]   q_ext;
  logic [NB_BIT:0]   dbl;
  logic [NB_BIT-1:0] dbl_red;
  logic [NB_BIT:0]   sum;

  // Both intermediates stay below 2q, so a single conditional subtract reduces them.
  always_comb begin
    q_ext   = {1'b0, q};
    dbl     = {r, 1'b0};
    dbl_red = (dbl >= q_ext) ? NB_BIT'(dbl - q_ext) : dbl[NB_BIT-1:0];
    sum     = {1'b0, dbl_red} + (b_bit ? {1'b0, a} : '0);
    r_next  = (sum >= q_ext) ? NB_BIT'(sum - q_ext) : sum[NB_BIT-1:0];
  end

endmodule

// File: rtl/mod_mul_seq.sv
// Sequential modular multiplier c = (a*b) mod q, one operation in flight.
// Define MOD_MUL_RADIX4_EN to consume two multiplier bits per cycle.
module mod_mul_seq
  import pq_pkg::*;
#(
  parameter int NB_BIT = Q_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [NB_BIT-1:0] a_i,
  input  logic [NB_BIT-1:0] b_i,
  input  logic [NB_BIT-1:0] q_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [NB_BIT-1:0] c_o
);

`ifdef MOD_MUL_RADIX4_EN
  localparam int RADIX_BITS = 2;
`else
  localparam int RADIX_BITS = 1;
`endif
  localparam int N     = steps_for(NB_BIT, RADIX_BITS);
  localparam int BW    = N * RADIX_BITS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [NB_BIT-1:0] r;
  logic [NB_BIT-1:0] r_step;
  logic [NB_BIT-1:0] a_q;
  logic [NB_BIT-1:0] q_q;
  logic [BW-1:0]     b_sh;
  logic              accept;

  assign accept = (state == IDLE) && in_valid_i;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid_i)      state_next = RUN;
      RUN:     if (cnt == '0)       state_next = DONE;
      DONE:    if (out_ready_i)     state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // Control and the accumulator are cleared by reset; operand registers are not.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      r     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        r   <= '0;
        cnt <= CNT_W'(N - 1);
      end else if (state == RUN) begin
        r   <= r_step;
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Multiplier is zero-padded at the top so an odd width still splits into whole digits.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      a_q  <= a_i;
      q_q  <= q_i;
      b_sh <= BW'(b_i);
    end else if (state == RUN) begin
      b_sh <= b_sh << RADIX_BITS;
    end
  end

`ifdef MOD_MUL_RADIX4_EN
  logic [NB_BIT-1:0] r_mid;

  mod_dbl_add #(.NB_BIT(NB_BIT)) u_step_hi (
    .r      (r),
    .b_bit  (b_sh[BW-1]),
    .a      (a_q),
    .q      (q_q),
    .r_next (r_mid)
  );

  mod_dbl_add #(.NB_BIT(NB_BIT)) u_step_lo (
    .r      (r_mid),
    .b_bit  (b_sh[BW-2]),
    .a      (a_q),
    .q      (q_q),
    .r_next (r_step)
  );
`else
  mod_dbl_add #(.NB_BIT(NB_BIT)) u_step (
    .r      (r),
    .b_bit  (b_sh[BW-1]),
    .a      (a_q),
    .q      (q_q),
    .r_next (r_step)
  );
`endif

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == DONE);
  assign c_o         = r;

endmodule

// File: tb/tb_mod_mul_seq.sv
// Scoreboard bench for mod_mul_seq: driver pushes expected results, a negedge
// monitor pops and checks them together with result latency and spacing.
module tb_mod_mul_seq;

`ifdef MOD_MUL_RADIX4_EN
  localparam int N = 12;
`else
  localparam int N = 23;
`endif
  localparam logic [22:0] QD = 23'd8380417;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [22:0] a = '0, b = '0, q = 23'd17;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [22:0] c;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  logic [22:0] exp_q[$];
  int          acc_q[$];
  logic prev_v = 1'b0;
  logic b2b = 1'b0;
  int   last_rise = -1;

  mod_mul_seq #(.NB_BIT(23)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .q_i         (q),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .c_o         (c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got %0d/%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Monitor: latency on the rising edge of out_valid, value on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (acc_q.size() == 0) check("spurious_valid", 1, 0);
        else check("latency", cyc - acc_q.pop_front(), N);
        if (b2b && last_rise >= 0) check("b2b_spacing", cyc - last_rise, N + 2);
        last_rise = cyc;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
        else check("result", c, exp_q.pop_front());
      end
      prev_v = out_valid;
    end
  end

  task automatic issue(input logic [22:0] qv, input logic [22:0] av,
                       input logic [22:0] bv, input logic [22:0] ev);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("in_ready_wait", 0, 1);
      return;
    end
    q = qv; a = av; b = bv;
    in_valid = 1'b1;
    exp_q.push_back(ev);
    acc_q.push_back(cyc + 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      check("drain", exp_q.size(), 0);
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  initial begin
    logic [22:0] qr, ar, br;
    int w;

    #12 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_c", c, 0);

    // Directed vectors with hand-computed products.
    issue(QD, 23'd2, 23'd3, 23'd6);
    issue(QD, 23'd8380416, 23'd8380416, 23'd1);
    issue(QD, 23'd0, 23'd8380416, 23'd0);
    issue(23'd17, 23'd5, 23'd7, 23'd1);
    issue(23'd17, 23'd16, 23'd16, 23'd1);
    issue(QD, 23'd1000, 23'd1000, 23'd1000000);
    issue(QD, 23'd4096, 23'd4096, 23'd16382);
    issue(QD, 23'd8380416, 23'd2, 23'd8380415);
    issue(23'd2, 23'd1, 23'd1, 23'd1);
    issue(23'd255, 23'd200, 23'd100, 23'd110);
    drain();

    // Consumer stall: result held, inputs ignored.
    @(posedge clk); #1 out_ready = 1'b0;
    issue(23'd17, 23'd5, 23'd7, 23'd1);
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("stall_valid_seen", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_c", c, 1);
      check("stall_in_ready", in_ready, 0);
      a = 23'd3; b = 23'd4; q = 23'd11;
      in_valid = (i % 2 == 0);
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
    @(negedge clk);
    check("release_stays_idle", in_ready, 1);
    drain();

    // Asynchronous reset in the middle of RUN.
    issue(QD, 23'd12345, 23'd6789, 23'd83810205 % 23'd8380417);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_c", c, 0);
    check("abort_in_ready", in_ready, 1);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(23'd17, 23'd9, 23'd11, 23'd14);
    drain();

    // Back-to-back traffic with the consumer always ready.
    b2b = 1'b1;
    last_rise = -1;
    issue(QD, 23'd2, 23'd3, 23'd6);
    issue(23'd17, 23'd5, 23'd7, 23'd1);
    issue(QD, 23'd8380416, 23'd8380416, 23'd1);
    issue(23'd255, 23'd200, 23'd100, 23'd110);
    drain();
    b2b = 1'b0;

    // Random operands checked against a 64-bit reference product.
    for (int i = 0; i < 60; i++) begin
      qr = (i % 2 == 0) ? QD : 23'($urandom_range(2, 8388607));
      ar = 23'($urandom_range(0, int'(qr) - 1));
      br = 23'($urandom_range(0, int'(qr) - 1));
      issue(qr, ar, br, 23'((64'(ar) * 64'(br)) % 64'(qr)));
    end
    drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
